// File: rtl/minisrc_control_unit.sv
// minisrc_control_unit: hardwired Mini SRC control sequencer.
//
// Runs the fetch steps T0-T2. It then decodes IR_Data[31:27] and runs the
// T3..T7 steps for that instruction class, one T-step per clock. Every datapath
// strobe is a Moore output of the current state and the opcode. The strobes are
// decoded combinationally from the state register because the IR loads on the
// edge that ends T2, and the T3 strobes must already reflect the new opcode.
//
// Ports:
//   clk, clr          clock; synchronous active-low reset (returns to IDLE)
//   run               start level in IDLE; a 0->1 edge restarts from HALT
//   IR_Data           instruction register contents, opcode in [31:27]
//   CON_out           branch condition, gates the branch PC load in T6
//   *_in / *_out      register load and bus drive strobes
//   Gra/Grb/Grc, Rin/Rout, BAout   register select and encode controls
//   Read, Write       memory strobes
//   alu_op            ALU operation code
//   halted            high while in HALT
//   illegal_op        sticky unassigned-opcode flag
//
// Build option: define MINISRC_ILLEGAL_TRAP_EN to make an unassigned opcode
// trap to HALT and set illegal_op. When it is undefined, an unassigned opcode
// behaves as a nop and illegal_op stays 0.
module minisrc_control_unit #(
  parameter logic [4:0] OP_ADD  = 5'b00011,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        IncPC,
  output logic        CON_in,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsUnary, ClsMulDiv, ClsLdi, ClsLd, ClsSt, ClsBr,
    ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
  } cls_e;

  state_e     state_q;
  state_e     last_st;
  cls_e       cls;
  logic       run_q;
  logic [4:0] opcode;
  logic [4:0] imm_op;
  logic       unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];

  // Instruction class decode. OP_NOP/OP_HALT are parameters, so they are
  // tested before the fixed opcode table.
  always_comb begin
    cls = ClsIllegal;
    if (opcode == OP_NOP) begin
      cls = ClsNop;
    end else if (opcode == OP_HALT) begin
      cls = ClsHalt;
    end else if (opcode >= 5'b00011 && opcode <= 5'b01011) begin
      cls = ClsAlu;
    end else begin
      case (opcode)
        5'b00000:                   cls = ClsLd;
        5'b00001:                   cls = ClsLdi;
        5'b00010:                   cls = ClsSt;
        5'b01100, 5'b01101, 5'b01110: cls = ClsImm;
        5'b01111, 5'b10000:         cls = ClsMulDiv;
        5'b10001, 5'b10010:         cls = ClsUnary;
        5'b10011:                   cls = ClsBr;
        5'b10100:                   cls = ClsJr;
        5'b10110:                   cls = ClsIn;
        5'b10111:                   cls = ClsOut;
        5'b11000:                   cls = ClsMfhi;
        5'b11001:                   cls = ClsMflo;
        default:                    cls = ClsIllegal;
      endcase
    end
  end

  // Immediate ALU ops map onto the add/and/or ALU codes.
  always_comb begin
    case (opcode)
      5'b01100: imm_op = OP_ADD;
      5'b01101: imm_op = 5'b00101;
      default:  imm_op = 5'b00110;
    endcase
  end

  // Final T-step of each class; it returns straight to T0 with no bubble.
  always_comb begin
    case (cls)
      ClsAlu, ClsImm, ClsLdi: last_st = StT5;
      ClsUnary:               last_st = StT4;
      ClsMulDiv, ClsBr:       last_st = StT6;
      ClsLd, ClsSt:           last_st = StT7;
      default:                last_st = StT3;
    endcase
  end

`ifdef MINISRC_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
`ifdef MINISRC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      run_q <= run;
      case (state_q)
        StIdle: if (run) state_q <= StT0;
        StT0:   state_q <= StT1;
        StT1:   state_q <= StT2;
        StT2:   state_q <= StT3;
        StT3: begin
          if (cls == ClsHalt) begin
            state_q <= StHalt;
`ifdef MINISRC_ILLEGAL_TRAP_EN
          end else if (cls == ClsIllegal) begin
            state_q   <= StHalt;
            illegal_q <= 1'b1;
`endif
          end else begin
            state_q <= (last_st == StT3) ? StT0 : StT4;
          end
        end
        StT4:   state_q <= (last_st == StT4) ? StT0 : StT5;
        StT5:   state_q <= (last_st == StT5) ? StT0 : StT6;
        StT6:   state_q <= (last_st == StT6) ? StT0 : StT7;
        StT7:   state_q <= StT0;
        // Restart only on a fresh rising edge of run, not a held level.
        StHalt: if (run && !run_q) state_q <= StT0;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0; HI_in = 1'b0;
    LO_in = 1'b0; MAR_in = 1'b0; MDR_in = 1'b0; OutPort_in = 1'b0; IncPC = 1'b0;
    CON_in = 1'b0; PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0;
    HI_out = 1'b0; LO_out = 1'b0; MDR_out = 1'b0; InPort_out = 1'b0;
    C_out = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Read = 1'b0; Write = 1'b0; alu_op = 5'b0;
    halted = (state_q == StHalt);
    case (state_q)
      StT0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
      StT1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
      StT2: begin MDR_out = 1'b1; IR_in = 1'b1; end
      StT3, StT4, StT5, StT6, StT7: begin
        case (cls)
          ClsAlu, ClsImm: begin
            case (state_q)
              StT3: begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
              StT4: begin
                Z_in = 1'b1;
                if (cls == ClsAlu) begin
                  Grc = 1'b1; Rout = 1'b1; alu_op = opcode;
                end else begin
                  C_out = 1'b1; alu_op = imm_op;
                end
              end
              StT5: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          ClsUnary: begin
            case (state_q)
              StT3: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_op = opcode; end
              StT4: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          ClsMulDiv: begin
            case (state_q)
              StT3: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
              StT4: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_op = opcode; end
              StT5: begin Zlow_out = 1'b1; LO_in = 1'b1; end
              StT6: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
              default: ;
            endcase
          end
          // ldi, ld and st share the effective-address steps T3-T4.
          ClsLdi, ClsLd, ClsSt: begin
            case (state_q)
              StT3: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
              StT4: begin C_out = 1'b1; Z_in = 1'b1; alu_op = OP_ADD; end
              StT5: begin
                Zlow_out = 1'b1;
                if (cls == ClsLdi) begin
                  Gra = 1'b1; Rin = 1'b1;
                end else begin
                  MAR_in = 1'b1;
                end
              end
              StT6: begin
                MDR_in = 1'b1;
                if (cls == ClsLd) begin
                  Read = 1'b1;
                end else begin
                  Gra = 1'b1; Rout = 1'b1;
                end
              end
              StT7: begin
                if (cls == ClsLd) begin
                  MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                  Write = 1'b1;
                end
              end
              default: ;
            endcase
          end
          ClsBr: begin
            case (state_q)
              StT3: begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
              StT4: begin PC_out = 1'b1; Y_in = 1'b1; end
              StT5: begin C_out = 1'b1; Z_in = 1'b1; alu_op = OP_ADD; end
              // Branch not taken: T6 is an empty step.
              StT6: begin Zlow_out = CON_out; PC_in = CON_out; end
              default: ;
            endcase
          end
          ClsJr:   if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
          ClsIn:   if (state_q == StT3) begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsOut:  if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
          ClsMfhi: if (state_q == StT3) begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMflo: if (state_q == StT3) begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
